cmp_minmax_window: RTL and testbench

Windowed min/max tracker that sits directly downstream of the 16-bit magnitude comparator. It accepts a stream of unsigned 16-bit samples over a valid/ready handshake and uses equal/greater/smaller decisions to track the running minimum and maximum and their arrival indices. After each window of WIN_LEN samples it presents one result record on a valid/ready output, then starts the next window.

---
 rtl/cmp_minmax_window_if.sv | 27 ++
 rtl/cmp_minmax_window.sv | 127 ++++++++++++
 tb/tb_cmp_minmax_window.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_minmax_window_if.sv
// Sample-in / record-out handshake bundle for the windowed min/max tracker.
// The master modport is the producer/consumer side; slave is the tracker itself.
interface cmp_minmax_window_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_min_idx;
    logic [IDX_W-1:0] out_max_idx;
    logic             out_all_eq;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_all_eq
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_all_eq
    );
endinterface

// File: rtl/cmp_minmax_window.sv
// Windowed min/max tracker: collects WIN_LEN unsigned samples, then holds one
// record (min, max, first-occurrence indices, all-equal flag) until it is taken.
module cmp_minmax_window #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned WIN_LEN = 8,
    parameter int unsigned IDX_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    cmp_minmax_window_if.slave  bus
);

    localparam int unsigned CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    // Running window extremes; the out_* registers only copy these at window end.
    logic [WIDTH-1:0] cur_min_q, cur_min_d;
    logic [WIDTH-1:0] cur_max_q, cur_max_d;
    logic [CNT_W-1:0] cur_min_idx_q, cur_min_idx_d;
    logic [CNT_W-1:0] cur_max_idx_q, cur_max_idx_d;

    logic [WIDTH-1:0] out_min_q, out_max_q;
    logic [IDX_W-1:0] out_min_idx_q, out_max_idx_q;
    logic             out_all_eq_q;

    logic accept;
    logic last_accept;
    logic is_less;
    logic is_greater;

    assign bus.in_ready  = (state_q == ST_ACCUM) && !clear;
    assign bus.out_valid = (state_q == ST_HOLD);

    assign accept      = bus.in_valid && bus.in_ready;
    assign last_accept = accept && (idx_q == LAST_IDX);
    assign is_less     = bus.in_data < cur_min_q;
    assign is_greater  = bus.in_data > cur_max_q;

    always_comb begin
        cur_min_d     = cur_min_q;
        cur_max_d     = cur_max_q;
        cur_min_idx_d = cur_min_idx_q;
        cur_max_idx_d = cur_max_idx_q;
        if (accept) begin
            if (idx_q == '0) begin
                cur_min_d     = bus.in_data;
                cur_max_d     = bus.in_data;
                cur_min_idx_d = '0;
                cur_max_idx_d = '0;
            end else if (is_less) begin
                cur_min_d     = bus.in_data;
                cur_min_idx_d = idx_q;
            end else if (is_greater) begin
                cur_max_d     = bus.in_data;
                cur_max_idx_d = idx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    idx_d = last_accept ? '0 : idx_q + CNT_W'(1);
                end
                if (last_accept) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ACCUM;
            idx_q         <= '0;
            cur_min_q     <= '0;
            cur_max_q     <= '0;
            cur_min_idx_q <= '0;
            cur_max_idx_q <= '0;
            out_min_q     <= '0;
            out_max_q     <= '0;
            out_min_idx_q <= '0;
            out_max_idx_q <= '0;
            out_all_eq_q  <= 1'b0;
        end else if (clear) begin
            // Abort wins over any handshake; the last record's data fields stay put.
            state_q <= ST_ACCUM;
            idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cur_min_q     <= cur_min_d;
            cur_max_q     <= cur_max_d;
            cur_min_idx_q <= cur_min_idx_d;
            cur_max_idx_q <= cur_max_idx_d;
            if (last_accept) begin
                out_min_q     <= cur_min_d;
                out_max_q     <= cur_max_d;
                out_min_idx_q <= IDX_W'(cur_min_idx_d);
                out_max_idx_q <= IDX_W'(cur_max_idx_d);
                out_all_eq_q  <= (cur_min_d == cur_max_d);
            end
        end
    end

    assign bus.out_min     = out_min_q;
    assign bus.out_max     = out_max_q;
    assign bus.out_min_idx = out_min_idx_q;
    assign bus.out_max_idx = out_max_idx_q;
    assign bus.out_all_eq  = out_all_eq_q;

endmodule

// File: tb/tb_cmp_minmax_window.sv
// Bench for cmp_minmax_window (WIN_LEN=4): directed windows plus random traffic,
// every cycle compared against a queue-based window model.
module tb_cmp_minmax_window;

    localparam int unsigned WIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    cmp_minmax_window_if #(.WIDTH(16), .IDX_W(8)) bus ();

    cmp_minmax_window #(
        .WIDTH   (16),
        .WIN_LEN (WIN),
        .IDX_W   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0] mn;
        logic [15:0] mx;
        logic [7:0]  mni;
        logic [7:0]  mxi;
        logic        eq;
    } rec_t;

    // Model state: whether a record is pending, the partial window, and the last record.
    logic        m_hold = 1'b0;
    logic [15:0] m_q[$];
    rec_t        m_rec = '0;

    function automatic rec_t summarize(input logic [15:0] s[$]);
        rec_t r;
        r.mn  = s[0];
        r.mx  = s[0];
        r.mni = 8'd0;
        r.mxi = 8'd0;
        for (int i = 1; i < s.size(); i++) begin
            if (s[i] < r.mn) begin
                r.mn  = s[i];
                r.mni = 8'(i);
            end
            if (s[i] > r.mx) begin
                r.mx  = s[i];
                r.mxi = 8'(i);
            end
        end
        r.eq = (r.mn == r.mx);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold <= 1'b0;
            m_q.delete();
            m_rec <= '0;
        end else if (clear) begin
            m_hold <= 1'b0;
            m_q.delete();
        end else if (!m_hold && bus.in_valid) begin
            m_q.push_back(bus.in_data);
            if (m_q.size() == WIN) begin
                m_rec  <= summarize(m_q);
                m_hold <= 1'b1;
                m_q.delete();
            end
        end else if (m_hold && bus.out_ready) begin
            m_hold <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(!m_hold && !clear));
        chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
        chk("out_min", 32'(bus.out_min), 32'(m_rec.mn));
        chk("out_max", 32'(bus.out_max), 32'(m_rec.mx));
        chk("out_min_idx", 32'(bus.out_min_idx), 32'(m_rec.mni));
        chk("out_max_idx", 32'(bus.out_max_idx), 32'(m_rec.mxi));
        chk("out_all_eq", 32'(bus.out_all_eq), 32'(m_rec.eq));
    end

    // Hand-computed record: pins both the DUT and the model.
    task automatic check_rec(input string name, input logic [15:0] mn, input logic [15:0] mx,
                             input logic [7:0] mni, input logic [7:0] mxi, input logic eq,
                             input logic vld);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(vld));
        chk({name, "_min"}, 32'(bus.out_min), 32'(mn));
        chk({name, "_max"}, 32'(bus.out_max), 32'(mx));
        chk({name, "_min_idx"}, 32'(bus.out_min_idx), 32'(mni));
        chk({name, "_max_idx"}, 32'(bus.out_max_idx), 32'(mxi));
        chk({name, "_all_eq"}, 32'(bus.out_all_eq), 32'(eq));
        chk({name, "_model"}, 32'({m_rec.mn, m_rec.mx}), 32'({mn, mx}));
        chk({name, "_model_idx"}, 32'({m_rec.mni, m_rec.mxi, 7'd0, m_rec.eq}),
            32'({mni, mxi, 7'd0, eq}));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a sample and leave in_valid high once it has been taken.
    task automatic push(input logic [15:0] d);
        logic acc;
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("push_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1 check_rec("reset", 16'h0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        step();
        rst = 1'b0;

        bus.out_ready = 1'b1;
        push(16'd5); push(16'd2); push(16'd9); push(16'd2);
        bus.in_valid = 1'b0;
        check_rec("basic", 16'd2, 16'd9, 8'd1, 8'd2, 1'b0, 1'b1);
        chk("basic_hold_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("basic_after_valid", 32'(bus.out_valid), 32'd0);
        chk("basic_after_ready", 32'(bus.in_ready), 32'd1);

        push(16'd7); push(16'd7); push(16'd7); push(16'd7);
        bus.in_valid = 1'b0;
        check_rec("all_eq", 16'd7, 16'd7, 8'd0, 8'd0, 1'b1, 1'b1);
        step();

        push(16'hFFFF); push(16'h0000); push(16'h8000); push(16'h7FFF);
        bus.in_valid = 1'b0;
        check_rec("limits", 16'h0000, 16'hFFFF, 8'd1, 8'd0, 1'b0, 1'b1);
        step();

        // Backpressure: record must sit still and no sample may slip in.
        bus.out_ready = 1'b0;
        push(16'd10); push(16'd20); push(16'd30); push(16'd40);
        bus.in_data = 16'd99;
        check_rec("bp_first", 16'd10, 16'd40, 8'd0, 8'd3, 1'b0, 1'b1);
        repeat (5) step();
        check_rec("bp_held", 16'd10, 16'd40, 8'd0, 8'd3, 1'b0, 1'b1);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        push(16'd98); push(16'd97); push(16'd96);
        bus.in_valid = 1'b0;
        check_rec("bp_next", 16'd96, 16'd99, 8'd3, 8'd0, 1'b0, 1'b1);
        step();

        push(16'd3); push(16'd1);
        clear = 1'b1;
        bus.in_data = 16'd77;
        step();
        clear = 1'b0;
        push(16'd6); push(16'd8); push(16'd4); push(16'd5);
        bus.in_valid = 1'b0;
        check_rec("clear", 16'd4, 16'd8, 8'd2, 8'd1, 1'b0, 1'b1);
        step();

        // Asynchronous reset while a record is pending.
        bus.out_ready = 1'b0;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        bus.in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1 check_rec("rst_hold", 16'h0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        push(16'd4); push(16'd3); push(16'd2); push(16'd1);
        bus.in_valid = 1'b0;
        check_rec("after_rst", 16'd1, 16'd4, 8'd3, 8'd0, 1'b0, 1'b1);
        step();

        repeat (600) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3))
                                                        : 16'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clear         = ($urandom_range(0, 40) == 0);
            step();
        end
        clear = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
